// File: rtl/servo_pwm_pkg.sv
// Shared register map, control-bit positions and width clamp for the servo PWM block.
package servo_pwm_pkg;

    typedef enum logic [7:0] {
        REG_TGT0   = 8'h00,
        REG_CUR0   = 8'h08,
        REG_CTRL   = 8'h10,
        REG_STAT   = 8'h11,
        REG_PERIOD = 8'h12
    } reg_addr_e;

    // Target and current widths occupy eight-register banks selected by addr[7:3].
    localparam logic [4:0] TGT_BANK = 5'(REG_TGT0 >> 3);
    localparam logic [4:0] CUR_BANK = 5'(REG_CUR0 >> 3);

    localparam int unsigned NUM_CH        = 8;
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_STEP_LSB = 8;

    function automatic logic [15:0] clamp_width(input logic [15:0] v,
                                                input logic [15:0] lo,
                                                input logic [15:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: clamped target, slewing current width and registered pulse compare.
module servo_channel
    import servo_pwm_pkg::*;
#(
    parameter int unsigned MIN_US = 500,
    parameter int unsigned MAX_US = 2500,
    parameter int unsigned DEF_US = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_tgt,
    input  logic [15:0] d_tgt,
    input  logic [15:0] cnt,
    input  logic        boundary,
    input  logic        enable,
    input  logic [7:0]  step,
    output logic [15:0] target,
    output logic [15:0] current,
    output logic        pwm
);

    logic [15:0] step_w;
    logic [15:0] diff;
    logic [15:0] next_cur;

    assign step_w = {8'b0, step};

    always_comb begin
        next_cur = current;
        diff     = (target >= current) ? (target - current) : (current - target);
        if (step == '0 || diff <= step_w) begin
            next_cur = target;
        end else if (target > current) begin
            next_cur = current + step_w;
        end else begin
            next_cur = current - step_w;
        end
    end

    // A target write landing on a boundary cycle is only seen by the following boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target  <= 16'(DEF_US);
            current <= 16'(DEF_US);
            pwm     <= 1'b0;
        end else begin
            if (wr_tgt) begin
                target <= clamp_width(d_tgt, 16'(MIN_US), 16'(MAX_US));
            end
            if (boundary) begin
                current <= next_cur;
            end
            pwm <= enable && (cnt < current);
        end
    end

endmodule

// File: rtl/servo_pwm8_core.sv
// Eight-channel servo PWM core: timebase, register decode, write-edge detect and readback.
module servo_pwm8_core
    import servo_pwm_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned TICK_HZ    = 1000000,
    parameter int unsigned PERIOD_DEF = 20000,
    parameter int unsigned PERIOD_MIN = 3000,
    parameter int unsigned MIN_US     = 500,
    parameter int unsigned MAX_US     = 2500,
    parameter int unsigned DEF_US     = 1500,
    parameter int unsigned STEP_DEF   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_in,
    input  logic [7:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        pwm0,
    output logic        pwm1,
    output logic        pwm2,
    output logic        pwm3,
    output logic        pwm4,
    output logic        pwm5,
    output logic        pwm6,
    output logic        pwm7
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc;
    logic [15:0]   cnt;
    logic [15:0]   active_period;
    logic [15:0]   period_reg;
    logic [7:0]    step;
    logic          enable;
    logic          wr_q;
    logic          wr_pulse;
    logic          tick;
    logic          boundary;
    logic          tgt_sel;
    logic [31:0]   rdata;
    logic [7:0]    moving;
    logic [7:0]    pwm_vec;
    logic [15:0]   target  [NUM_CH];
    logic [15:0]   current [NUM_CH];
    logic          unused_bits;

    assign unused_bits = &{1'b0, d_in[31:16]};
    assign wr_pulse    = wr && !wr_q;
    assign tick        = enable && (presc == PW'(DIV - 1));
    assign boundary    = tick && (cnt == active_period - 16'd1);
    assign tgt_sel     = (addr[7:3] == TGT_BANK);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_channel #(
            .MIN_US(MIN_US),
            .MAX_US(MAX_US),
            .DEF_US(DEF_US)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_tgt  (wr_pulse && tgt_sel && (addr[2:0] == 3'(i))),
            .d_tgt   (d_in[15:0]),
            .cnt     (cnt),
            .boundary(boundary),
            .enable  (enable),
            .step    (step),
            .target  (target[i]),
            .current (current[i]),
            .pwm     (pwm_vec[i])
        );
        assign moving[i] = (current[i] != target[i]);
    end

    assign {pwm7, pwm6, pwm5, pwm4, pwm3, pwm2, pwm1, pwm0} = pwm_vec;

    always_comb begin
        rdata = '0;
        if (tgt_sel) begin
            rdata = {16'b0, target[addr[2:0]]};
        end else if (addr[7:3] == CUR_BANK) begin
            rdata = {16'b0, current[addr[2:0]]};
        end else if (addr == REG_CTRL) begin
            rdata = {16'b0, step, 7'b0, enable};
        end else if (addr == REG_STAT) begin
            rdata = {24'b0, moving};
        end else if (addr == REG_PERIOD) begin
            rdata = {16'b0, period_reg};
        end
    end

    // Counters sit at zero while disabled, so re-enabling always opens a fresh period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out         <= '0;
            wr_q          <= 1'b0;
            enable        <= 1'b0;
            step          <= 8'(STEP_DEF);
            period_reg    <= 16'(PERIOD_DEF);
            active_period <= 16'(PERIOD_DEF);
            presc         <= '0;
            cnt           <= '0;
        end else begin
            wr_q <= wr;
            if (rd) begin
                d_out <= rdata;
            end
            if (wr_pulse && addr == REG_CTRL) begin
                enable <= d_in[CTRL_EN_BIT];
                step   <= d_in[CTRL_STEP_LSB +: 8];
            end
            if (wr_pulse && addr == REG_PERIOD) begin
                period_reg <= (d_in[15:0] < 16'(PERIOD_MIN)) ? 16'(PERIOD_MIN) : d_in[15:0];
            end
            if (!enable) begin
                presc <= '0;
                cnt   <= '0;
            end else if (tick) begin
                presc <= '0;
                cnt   <= boundary ? 16'd0 : cnt + 16'd1;
                if (boundary) begin
                    active_period <= period_reg;
                end
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm8_core.sv
// Directed scoreboard bench for servo_pwm8_core with a one-clock tick and a short minimum period.
module tb_servo_pwm8_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_in;
    logic [7:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;
    logic        pwm0, pwm1, pwm2, pwm3, pwm4, pwm5, pwm6, pwm7;
    logic [7:0]  pwm;

    assign pwm = {pwm7, pwm6, pwm5, pwm4, pwm3, pwm2, pwm1, pwm0};

    always #5 clk = ~clk;

    servo_pwm8_core #(
        .CLK_HZ    (1000000),
        .TICK_HZ   (1000000),
        .PERIOD_MIN(600)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .d_in (d_in),
        .addr (addr),
        .rd   (rd),
        .wr   (wr),
        .d_out(d_out),
        .pwm0 (pwm0),
        .pwm1 (pwm1),
        .pwm2 (pwm2),
        .pwm3 (pwm3),
        .pwm4 (pwm4),
        .pwm5 (pwm5),
        .pwm6 (pwm6),
        .pwm7 (pwm7)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic expect_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic compare_pop(input logic [31:0] obs);
        exp_t e;
        e.tag = "scoreboard_underflow";
        e.val = 'x;
        if (sb.size() != 0) e = sb.pop_front();
        vectors++;
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        d_in = d;
        wr   = 1'b1;
        @(negedge clk);
        wr   = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a;
        rd   = 1'b1;
        expect_push(tag, exp);
        @(negedge clk);
        rd   = 1'b0;
        compare_pop(d_out);
    endtask

    task automatic wait_pwm(input int unsigned ch, input logic level,
                            input int unsigned limit, output logic found);
        found = 1'b0;
        for (int unsigned i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (pwm[ch] === level) found = 1'b1;
        end
    endtask

    // Returns on the first sample of a new period for a channel narrower than the period.
    task automatic wait_rise(input string tag, input int unsigned ch);
        logic f0, f1;
        wait_pwm(ch, 1'b0, 1300, f0);
        wait_pwm(ch, 1'b1, 1300, f1);
        expect_push(tag, 32'd1);
        compare_pop({31'b0, f0 & f1});
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found;
        int unsigned hi [8];
        int unsigned lo_cnt;
        logic        p_last_hi, p_first_lo;

        rst = 1'b0; d_in = '0; addr = '0; rd = 1'b0; wr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_push("rst_dout", 32'd0);
        compare_pop(d_out);
        expect_push("rst_pwm", 32'd0);
        compare_pop({24'b0, pwm});
        rd_reg("rst_tgt0", 8'h00, 32'h0000_05DC);
        rd_reg("rst_ctrl", 8'h10, 32'h0000_0A00);
        rd_reg("rst_cur7", 8'h0F, 32'd1500);
        rd_reg("rst_stat", 8'h11, 32'd0);
        rd_reg("rst_period", 8'h12, 32'd20000);
        rd_reg("unmapped_rd", 8'h20, 32'd0);

        wr_reg(8'h00, 32'd100);
        rd_reg("clamp_lo", 8'h00, 32'd500);
        wr_reg(8'h00, 32'd9000);
        rd_reg("clamp_hi", 8'h00, 32'd2500);
        wr_reg(8'h00, 32'd1500);
        rd_reg("tgt0_restore", 8'h00, 32'd1500);
        @(negedge clk);
        expect_push("dout_hold", 32'd1500);
        compare_pop(d_out);
        wr_reg(8'h08, 32'd700);
        rd_reg("cur_readonly", 8'h08, 32'd1500);
        wr_reg(8'h20, 32'h0000_FFFF);
        rd_reg("unmapped_wr", 8'h20, 32'd0);

        // wr held high across three data values: only the first is committed
        @(negedge clk); addr = 8'h01; d_in = 32'd1000; wr = 1'b1;
        @(negedge clk); d_in = 32'd1200;
        @(negedge clk); d_in = 32'd1300;
        @(negedge clk); wr = 1'b0;
        rd_reg("wr_held", 8'h01, 32'd1000);
        wr_reg(8'h01, 32'd1500);

        wr_reg(8'h10, 32'h0000_0A01);
        wait_pwm(0, 1'b1, 10, found);
        expect_push("enable_start", 32'd1);
        compare_pop({31'b0, found});
        for (int unsigned c = 0; c < 8; c++) hi[c] = 0;
        p_last_hi = 1'b0;
        p_first_lo = 1'b1;
        for (int unsigned s = 0; s < 20000; s++) begin
            if (s != 0) @(negedge clk);
            for (int unsigned c = 0; c < 8; c++) if (pwm[c] === 1'b1) hi[c]++;
            if (s == 1499) p_last_hi = pwm[0];
            if (s == 1500) p_first_lo = pwm[0];
        end
        for (int unsigned c = 0; c < 8; c++) begin
            expect_push($sformatf("high_count_ch%0d", c), 32'd1500);
            compare_pop(hi[c]);
        end
        expect_push("pwm0_last_high", 32'd1);
        compare_pop({31'b0, p_last_hi});
        expect_push("pwm0_first_low", 32'd0);
        compare_pop({31'b0, p_first_lo});
        @(negedge clk);
        expect_push("period_wrap_all_high", 32'h0000_00FF);
        compare_pop({24'b0, pwm});

        wr_reg(8'h12, 32'd100);
        rd_reg("period_clamp", 8'h12, 32'd600);
        wait_pwm(0, 1'b0, 20000, found);
        expect_push("old_period_fall", 32'd1);
        compare_pop({31'b0, found});
        lo_cnt = 1;
        found = 1'b0;
        for (int unsigned i = 0; i < 20000 && !found; i++) begin
            @(negedge clk);
            if (pwm[0] === 1'b1) found = 1'b1;
            else lo_cnt++;
        end
        expect_push("old_period_low_len", 32'd18500);
        compare_pop(lo_cnt);
        repeat (1600) @(negedge clk);
        expect_push("new_period_active", 32'd1);
        compare_pop({31'b0, pwm[0]});

        wr_reg(8'h10, 32'h0000_0001);
        wr_reg(8'h06, 32'd800);
        wr_reg(8'h07, 32'd500);
        wait_pwm(7, 1'b0, 1300, found);
        expect_push("step0_fall", 32'd1);
        compare_pop({31'b0, found});
        rd_reg("step0_cur6", 8'h0E, 32'd800);
        rd_reg("step0_cur7", 8'h0F, 32'd500);
        rd_reg("step0_stat", 8'h11, 32'd0);
        rd_reg("step0_ctrl", 8'h10, 32'h0000_0001);

        wr_reg(8'h10, 32'h0000_0A01);
        wait_rise("slew_sync", 7);
        wr_reg(8'h03, 32'd2000);
        wait_rise("slew_b1", 7);
        rd_reg("slew_cur3_b1", 8'h0B, 32'd1510);
        rd_reg("slew_stat_b1", 8'h11, 32'h0000_0008);
        for (int unsigned b = 2; b <= 49; b++) wait_rise($sformatf("slew_b%0d", b), 7);
        rd_reg("slew_cur3_b49", 8'h0B, 32'd1990);
        rd_reg("slew_stat_b49", 8'h11, 32'h0000_0008);
        wait_rise("slew_b50", 7);
        rd_reg("slew_cur3_b50", 8'h0B, 32'd2000);
        rd_reg("slew_stat_b50", 8'h11, 32'd0);

        // place the target write on the exact boundary clock
        wait_rise("bnd_sync", 7);
        repeat (597) @(negedge clk);
        wr_reg(8'h05, 32'd2000);
        rd_reg("bnd_uses_old_tgt", 8'h0D, 32'd1500);
        wait_rise("bnd_next", 7);
        rd_reg("bnd_next_cur5", 8'h0D, 32'd1510);
        rd_reg("bnd_tgt5", 8'h05, 32'd2000);

        wr_reg(8'h10, 32'h0000_0A00);
        expect_push("pre_disable_pwm0", 32'd1);
        compare_pop({31'b0, pwm[0]});
        @(negedge clk);
        expect_push("disable_pwm_low", 32'd0);
        compare_pop({24'b0, pwm});
        repeat (700) @(negedge clk);
        expect_push("disable_pwm_hold", 32'd0);
        compare_pop({24'b0, pwm});
        rd_reg("disable_cur5_frozen", 8'h0D, 32'd1510);
        wr_reg(8'h04, 32'd600);
        rd_reg("disable_tgt_write", 8'h04, 32'd600);

        wr_reg(8'h10, 32'h0000_0A01);
        wait_pwm(0, 1'b1, 10, found);
        expect_push("reenable_start", 32'd1);
        compare_pop({31'b0, found});
        rd_reg("pre_reset_tgt5", 8'h05, 32'd2000);
        #2;
        rst = 1'b0;
        #1;
        expect_push("async_rst_pwm", 32'd0);
        compare_pop({24'b0, pwm});
        expect_push("async_rst_dout", 32'd0);
        compare_pop(d_out);
        @(negedge clk);
        rst = 1'b1;
        rd_reg("post_rst_tgt5", 8'h05, 32'd1500);
        rd_reg("post_rst_tgt4", 8'h04, 32'd1500);
        rd_reg("post_rst_cur5", 8'h0D, 32'd1500);
        rd_reg("post_rst_ctrl", 8'h10, 32'h0000_0A00);
        rd_reg("post_rst_period", 8'h12, 32'd20000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/servo_pwm8_core.md
Name: servo_pwm8_core

Overview:
8-channel servo PWM generator for the cube-turning motors. It sits directly downstream of the Wishbone motor wrapper and consumes that wrapper's register-style command interface (d_in, addr, rd, wr). It drives pwm0..pwm7 to the servo drivers and returns readback on d_out. Each channel has a target pulse width and a current pulse width. The current width slews toward the target once per PWM period, so motors turn smoothly.

Parameters:
CLK_HZ, 50000000, system clock frequency
TICK_HZ, 1000000, pulse-width resolution tick (1 us); divider = CLK_HZ/TICK_HZ, must be >= 1
PERIOD_DEF, 20000, reset PWM period in ticks (50 Hz)
PERIOD_MIN, 3000, smallest accepted period in ticks
MIN_US, 500, lower clamp for pulse width in ticks
MAX_US, 2500, upper clamp for pulse width in ticks
DEF_US, 1500, reset target and current width (centre position)
STEP_DEF, 10, reset slew step in ticks per period

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
d_in  in  32  write data
addr  in  8  register address
rd  in  1  read enable, level
wr  in  1  write request; acted on only at its rising edge
d_out  out  32  registered readback
pwm0..pwm7  out  1 each  servo pulse outputs

Behaviour:
- Reset (rst=0, async): pwm* = 0, d_out = 0, all targets and currents = DEF_US, enable = 0, step = STEP_DEF, period = PERIOD_DEF, prescaler = 0, period counter = 0, wr edge register = 0.
- Write: wr is sampled every clk. A 0->1 transition commits d_in to addr on that cycle. A held-high wr produces no further writes.
- Register map:
  - 0x00-0x07: target width of channel n, d_in[15:0], clamped to [MIN_US, MAX_US]. Read returns the clamped target.
  - 0x08-0x0F: current width of channel n. Read-only; writes are ignored.
  - 0x10: control. Bit0 = enable; bits[15:8] = step. Read returns {16'b0, step, 7'b0, enable}.
  - 0x11: status, read-only. Bits[7:0] = moving[n] = (current_n != target_n).
  - 0x12: period, d_in[15:0]. Values < PERIOD_MIN are stored as PERIOD_MIN. The new value is loaded into the active period at the next period boundary. Read returns the stored (pending) value.
  - Unmapped addresses: writes are ignored; reads return 0.
- Read: if rd=1, d_out <= reg[addr] on the next clk (1-cycle latency). If rd=0, d_out holds its value.
- Timebase:
  - The prescaler counts 0..CLK_HZ/TICK_HZ-1 and emits a 1-cycle tick at wrap.
  - The period counter cnt increments on each tick and wraps at active_period-1.
  - The boundary is the tick on which cnt wraps to 0.
- Output: pwm_n = enable & (cnt < current_n), registered, so 1 cycle of latency after cnt changes.
- Slew, at each boundary, per channel:
  - If step = 0: current = target.
  - Else if |target - current| <= step: current = target.
  - Else: current moves by step toward target.
  - The boundary uses the target value from before any write in the same cycle. A simultaneous write is registered and applies at the next boundary.
- Enable 0->1: prescaler and cnt are cleared, so a fresh period starts with its pulses high.
- Enable 1->0: pwm* go low the next cycle. Counters hold at 0. Currents freeze. Targets remain writable.
- Reset mid-pulse: outputs drop immediately (async) and all state returns to reset values.

Decomposition:
- Package servo_pwm_pkg: register address constants (REG_TGT0, REG_CUR0, REG_CTRL, REG_STAT, REG_PERIOD) and control-bit positions.
- One sub-module, servo_channel, instantiated 8 times. Each instance holds target/current registers, clamp, slew step and compare, with inputs cnt, boundary, enable and step.
- Top level holds the prescaler, period counter, register decode, wr edge detect and d_out mux.

Test Plan:
- Reset (sim params CLK_HZ=TICK_HZ=1e6, divider 1): release rst -> d_out=0, pwm*=0. Read 0x00 -> 1500 (0x5DC). Read 0x10 -> 0x00000A00.
- Write 0x10=0x00000001, then count cycles: pwm0 high 1500 clks, low 18500 clks, period 20000. All 8 channels match.
- Write 0x03=2000 with step=10: current_3 reads 1510 after the first boundary and 2000 after the 50th. Status bit3 is 1 until then, 0 after.
- Clamps: write 0x00=100 -> read 500. Write 0x00=9000 -> read 2500. Write 0x12=1000 -> read 3000, and the new period takes effect only after the current 20000-tick period ends.
- Write semantics: hold wr=1 across two d_in changes -> only the first value is written. Write 0x05 on a boundary cycle -> that boundary uses the old target.
- Step=0 (0x10=0x00000001) then target 800 -> current reads 800 after one boundary. Deassert enable mid-pulse -> pwm low next cycle. Assert rst=0 mid-pulse -> pwm low without a clock edge.
